// File: rtl/ac97_frame_tx_if.sv
// Mixer-side bundle of the AC'97 transmitter: PCM samples, codec command request and the serial pins.
// Master drives the request side; slave is the frame transmitter.
interface ac97_frame_tx_if #(
    parameter int SAMPLE_WIDTH = 20
) ();
    logic                    I_CODEC_READY;
    logic [SAMPLE_WIDTH-1:0] I_LEFT_SAMPLE;
    logic [SAMPLE_WIDTH-1:0] I_RIGHT_SAMPLE;
    logic                    I_CMD_VALID;
    logic                    I_CMD_WRITE;
    logic [6:0]              I_CMD_ADDR;
    logic [15:0]             I_CMD_DATA;
    logic                    O_CMD_READY;
    logic                    O_SYNC;
    logic                    O_SDATA_OUT;
    logic                    O_FRAME_STROBE;

    modport master (
        output I_CODEC_READY, I_LEFT_SAMPLE, I_RIGHT_SAMPLE,
        output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA,
        input  O_CMD_READY, O_SYNC, O_SDATA_OUT, O_FRAME_STROBE
    );

    modport slave (
        input  I_CODEC_READY, I_LEFT_SAMPLE, I_RIGHT_SAMPLE,
        input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA,
        output O_CMD_READY, O_SYNC, O_SDATA_OUT, O_FRAME_STROBE
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// AC'97 SDATA_OUT/SYNC frame builder: one optional codec command plus a stereo sample per 256-bit frame.
// Outputs registered, one bit per BIT_CLK; a command waits in a one-deep holding reg (ready low) until sent.
module ac97_frame_tx #(
    parameter int SAMPLE_WIDTH = 20,
    parameter int STROBE_BIT   = 0
) (
    input  logic              I_CLK,
    input  logic              I_RESET_L,
    ac97_frame_tx_if.slave    bus
);
    // cnt_q is the index of the frame bit presented by the next edge.
    logic [7:0]              cnt_q, cnt_d;
    logic                    cr_q, cr_d;
    logic                    ld_q, ld_d;
    logic                    fwr_q, fwr_d;
    logic [6:0]              faddr_q, faddr_d;
    logic [15:0]             fdata_q, fdata_d;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic [SAMPLE_WIDTH-1:0] right_q, right_d;
    logic                    hfull_q, hfull_d;
    logic                    hwr_q, hwr_d;
    logic [6:0]              haddr_q, haddr_d;
    logic [15:0]             hdata_q, hdata_d;
    logic                    rdy_q, rdy_d;
    logic                    sync_q, sync_d;
    logic                    sdata_q, sdata_d;
    logic                    strobe_q, strobe_d;
    logic [19:0]             l20, r20;

    always_comb begin
        cnt_d    = cnt_q + 8'd1;
        cr_d     = cr_q;
        ld_d     = ld_q;
        fwr_d    = fwr_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        left_d   = left_q;
        right_d  = right_q;
        hfull_d  = hfull_q;
        hwr_d    = hwr_q;
        haddr_d  = haddr_q;
        hdata_d  = hdata_q;
        sdata_d  = 1'b0;
        l20      = '0;
        r20      = '0;

        // Frame start: the load decision uses the holding reg as it was before this edge's accept.
        if (cnt_q == 8'd0) begin
            cr_d    = bus.I_CODEC_READY;
            left_d  = bus.I_LEFT_SAMPLE;
            right_d = bus.I_RIGHT_SAMPLE;
            ld_d    = hfull_q & bus.I_CODEC_READY;
            if (ld_d) begin
                fwr_d   = hwr_q;
                faddr_d = haddr_q;
                fdata_d = hdata_q;
                hfull_d = 1'b0;
            end
        end

        if (bus.I_CMD_VALID && rdy_q) begin
            hfull_d = 1'b1;
            hwr_d   = bus.I_CMD_WRITE;
            haddr_d = bus.I_CMD_ADDR;
            hdata_d = bus.I_CMD_DATA;
        end

        rdy_d    = ~hfull_d;
        sync_d   = (cnt_q < 8'd16);
        strobe_d = (cnt_q == 8'(STROBE_BIT));

        l20 = 20'(left_d)  << (20 - SAMPLE_WIDTH);
        r20 = 20'(right_d) << (20 - SAMPLE_WIDTH);

        if (cnt_q == 8'd0)
            sdata_d = cr_d;
        else if (cnt_q == 8'd1)
            sdata_d = ld_d;
        else if (cnt_q == 8'd2)
            sdata_d = ld_d & fwr_d;
        else if (cnt_q == 8'd3 || cnt_q == 8'd4)
            sdata_d = cr_d;
        else if (cnt_q == 8'd16)
            sdata_d = ld_d & ~fwr_d;
        else if (cnt_q >= 8'd17 && cnt_q <= 8'd23)
            sdata_d = ld_d & faddr_d[3'(8'd23 - cnt_q)];
        else if (cnt_q >= 8'd36 && cnt_q <= 8'd51)
            sdata_d = ld_d & fwr_d & fdata_d[4'(8'd51 - cnt_q)];
        else if (cnt_q >= 8'd56 && cnt_q <= 8'd75)
            sdata_d = cr_d & l20[5'(8'd75 - cnt_q)];
        else if (cnt_q >= 8'd76 && cnt_q <= 8'd95)
            sdata_d = cr_d & r20[5'(8'd95 - cnt_q)];
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            cnt_q    <= '0;
            cr_q     <= 1'b0;
            ld_q     <= 1'b0;
            fwr_q    <= 1'b0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            hfull_q  <= 1'b0;
            hwr_q    <= 1'b0;
            haddr_q  <= '0;
            hdata_q  <= '0;
            rdy_q    <= 1'b1;
            sync_q   <= 1'b0;
            sdata_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cr_q     <= cr_d;
            ld_q     <= ld_d;
            fwr_q    <= fwr_d;
            faddr_q  <= faddr_d;
            fdata_q  <= fdata_d;
            left_q   <= left_d;
            right_q  <= right_d;
            hfull_q  <= hfull_d;
            hwr_q    <= hwr_d;
            haddr_q  <= haddr_d;
            hdata_q  <= hdata_d;
            rdy_q    <= rdy_d;
            sync_q   <= sync_d;
            sdata_q  <= sdata_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.O_CMD_READY    = rdy_q;
    assign bus.O_SYNC         = sync_q;
    assign bus.O_SDATA_OUT    = sdata_q;
    assign bus.O_FRAME_STROBE = strobe_q;
endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: frame-level reference model plus directed scenarios and random traffic.
module tb_ac97_frame_tx;
    localparam int SW = 20;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ac97_frame_tx_if #(.SAMPLE_WIDTH(SW)) bus0 ();
    ac97_frame_tx_if #(.SAMPLE_WIDTH(SW)) bus1 ();

    assign bus1.I_CODEC_READY  = bus0.I_CODEC_READY;
    assign bus1.I_LEFT_SAMPLE  = bus0.I_LEFT_SAMPLE;
    assign bus1.I_RIGHT_SAMPLE = bus0.I_RIGHT_SAMPLE;
    assign bus1.I_CMD_VALID    = bus0.I_CMD_VALID;
    assign bus1.I_CMD_WRITE    = bus0.I_CMD_WRITE;
    assign bus1.I_CMD_ADDR     = bus0.I_CMD_ADDR;
    assign bus1.I_CMD_DATA     = bus0.I_CMD_DATA;

    ac97_frame_tx #(.SAMPLE_WIDTH(SW), .STROBE_BIT(0)) dut0 (
        .I_CLK(clk), .I_RESET_L(rst_n), .bus(bus0.slave)
    );
    ac97_frame_tx #(.SAMPLE_WIDTH(SW), .STROBE_BIT(200)) dut1 (
        .I_CLK(clk), .I_RESET_L(rst_n), .bus(bus1.slave)
    );

    int          errors = 0;
    int          checks = 0;
    cmd_t        q[$];
    int          nk;
    int          last_k;
    logic        m_full;
    logic        m_ready;
    cmd_t        m_hold;
    logic [0:255] exp_f;
    logic [0:255] cap;

    function automatic logic [0:255] build_frame(input logic cr, input logic ld, input cmd_t c,
                                                 input logic [SW-1:0] l, input logic [SW-1:0] r);
        logic [0:255] f;
        logic [19:0]  l20;
        logic [19:0]  r20;
        f   = '0;
        l20 = 20'(l) << (20 - SW);
        r20 = 20'(r) << (20 - SW);
        f[0] = cr;
        f[1] = ld;
        f[2] = ld & c.wr;
        f[3] = cr;
        f[4] = cr;
        if (ld) begin
            f[16]    = ~c.wr;
            f[17:23] = c.addr;
            if (c.wr) f[36:51] = c.data;
        end
        if (cr) begin
            f[56:75] = l20;
            f[76:95] = r20;
        end
        return f;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BIT_CLK: drive the request, advance the model across the edge, then compare all outputs.
    task automatic tick();
        int   k;
        logic cr;
        logic ld;
        k = nk;
        bus0.I_CMD_VALID = (q.size() > 0);
        if (q.size() > 0) begin
            bus0.I_CMD_WRITE = q[0].wr;
            bus0.I_CMD_ADDR  = q[0].addr;
            bus0.I_CMD_DATA  = q[0].data;
        end
        @(posedge clk);
        if (k == 0) begin
            cr = bus0.I_CODEC_READY;
            ld = m_full & cr;
            if (ld) m_full = 1'b0;
            exp_f = build_frame(cr, ld, m_hold, bus0.I_LEFT_SAMPLE, bus0.I_RIGHT_SAMPLE);
        end
        if (bus0.I_CMD_VALID && m_ready) begin
            m_hold = q.pop_front();
            m_full = 1'b1;
        end
        m_ready = ~m_full;
        #1;
        cap[k] = bus0.O_SDATA_OUT;
        chk1($sformatf("sdata[%0d]", k), bus0.O_SDATA_OUT, exp_f[k]);
        chk1($sformatf("sync[%0d]", k), bus0.O_SYNC, k < 16);
        chk1($sformatf("strobe0[%0d]", k), bus0.O_FRAME_STROBE, k == 0);
        chk1($sformatf("strobe200[%0d]", k), bus1.O_FRAME_STROBE, k == 200);
        chk1($sformatf("ready[%0d]", k), bus0.O_CMD_READY, m_ready);
        last_k = k;
        nk = (k + 1) % 256;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (last_k == target) break;
        end
    endtask

    task automatic do_reset(input int hold_cycles);
        rst_n = 1'b0;
        bus0.I_CMD_VALID = 1'b0;
        #1;
        chk1("rst_sync", bus0.O_SYNC, 1'b0);
        chk1("rst_sdata", bus0.O_SDATA_OUT, 1'b0);
        chk1("rst_strobe0", bus0.O_FRAME_STROBE, 1'b0);
        chk1("rst_strobe200", bus1.O_FRAME_STROBE, 1'b0);
        chk1("rst_ready", bus0.O_CMD_READY, 1'b1);
        m_full  = 1'b0;
        m_ready = 1'b1;
        nk      = 0;
        last_k  = 255;
        q.delete();
        repeat (hold_cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n                = 1'b1;
        bus0.I_CODEC_READY   = 1'b1;
        bus0.I_LEFT_SAMPLE   = 20'hA5A5A;
        bus0.I_RIGHT_SAMPLE  = 20'h0F0F1;
        bus0.I_CMD_VALID     = 1'b0;
        bus0.I_CMD_WRITE     = 1'b0;
        bus0.I_CMD_ADDR      = '0;
        bus0.I_CMD_DATA      = '0;
        m_hold               = '0;
        exp_f                = '0;
        cap                  = '0;
        #2;
        do_reset(3);

        // Plain frame, no command.
        run_until(255);
        chkv("slot0", 256'(cap[0:15]), 256'(16'b1001_1000_0000_0000));
        chkv("left", 256'(cap[56:75]), 256'(20'hA5A5A));
        chkv("right", 256'(cap[76:95]), 256'(20'h0F0F1));
        chkv("zero16_55", 256'(cap[16:55]), 256'(0));
        chkv("zero96_255", 256'(cap[96:255]), 256'(0));

        // Mid-frame register write.
        run_until(100);
        q.push_back('{wr: 1'b1, addr: 7'h02, data: 16'h8000});
        tick();
        chk1("wr_ready_low", bus0.O_CMD_READY, 1'b0);
        run_until(255);
        tick();
        chk1("wr_ready_back", bus0.O_CMD_READY, 1'b1);
        run_until(255);
        chkv("wr_tags", 256'(cap[0:4]), 256'(5'b11111));
        chk1("wr_bit16", cap[16], 1'b0);
        chkv("wr_addr", 256'(cap[17:23]), 256'(7'b0000010));
        chkv("wr_data", 256'(cap[36:51]), 256'(16'h8000));

        // Register read.
        run_until(10);
        q.push_back('{wr: 1'b0, addr: 7'h7C, data: 16'hFFFF});
        run_until(255);
        run_until(255);
        chk1("rd_tag1", cap[1], 1'b1);
        chk1("rd_tag2", cap[2], 1'b0);
        chk1("rd_bit16", cap[16], 1'b1);
        chkv("rd_addr", 256'(cap[17:23]), 256'(7'b1111100));
        chkv("rd_zero36_55", 256'(cap[36:55]), 256'(0));

        // Command presented on the frame-start edge, then a second one behind it.
        q.push_back('{wr: 1'b1, addr: 7'h11, data: 16'h1234});
        tick();
        q.push_back('{wr: 1'b1, addr: 7'h26, data: 16'hBEEF});
        tick();
        chk1("fs_blocked", bus0.O_CMD_READY, 1'b0);
        run_until(255);
        chk1("fs_not_this_frame", cap[1], 1'b0);
        run_until(255);
        chk1("fs_next_tag", cap[1], 1'b1);
        chkv("fs_next_addr", 256'(cap[17:23]), 256'(7'h11));
        chkv("fs_next_data", 256'(cap[36:51]), 256'(16'h1234));
        run_until(255);
        chkv("second_addr", 256'(cap[17:23]), 256'(7'h26));
        chkv("second_data", 256'(cap[36:51]), 256'(16'hBEEF));

        // Codec not ready: command held, frames empty until CR rises and a frame starts.
        bus0.I_CODEC_READY = 1'b0;
        q.push_back('{wr: 1'b1, addr: 7'h2C, data: 16'hBB80});
        run_until(255);
        chkv("cr0_frame", 256'(cap), 256'(0));
        chk1("cr0_ready", bus0.O_CMD_READY, 1'b0);
        run_until(100);
        bus0.I_CODEC_READY = 1'b1;
        run_until(255);
        chkv("cr_rise_frame", 256'(cap), 256'(0));
        run_until(255);
        chkv("cr1_tags", 256'(cap[0:4]), 256'(5'b11111));
        chkv("cr1_addr", 256'(cap[17:23]), 256'(7'h2C));

        // Reset at bit 60 with a command held.
        run_until(30);
        q.push_back('{wr: 1'b1, addr: 7'h55, data: 16'h5555});
        run_until(60);
        do_reset(2);
        tick();
        chk1("post_rst_ready", bus0.O_CMD_READY, 1'b1);
        run_until(255);
        chkv("post_rst_slot0", 256'(cap[0:4]), 256'(5'b10011));

        // Random traffic.
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 256; b++) begin
                if (q.size() == 0 && $urandom_range(0, 99) < 3)
                    q.push_back('{wr: 1'($urandom), addr: 7'($urandom), data: 16'($urandom)});
                if ($urandom_range(0, 299) == 0)
                    bus0.I_CODEC_READY = ~bus0.I_CODEC_READY;
                if (last_k == 0) begin
                    bus0.I_LEFT_SAMPLE  = 20'($urandom);
                    bus0.I_RIGHT_SAMPLE = 20'($urandom);
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
